// File: rtl/reg_file_32x32_if.sv
// Register-file access bundle: one write port and two read ports.
//   reg_write/write_reg/write_data : write-back port (value from 3-input select stage)
//   read_reg1/read_reg2            : read addresses
//   read_data1/read_data2          : combinational read data (with write bypass)
// master = datapath side driving addresses/write-back, slave = register file.
interface reg_file_32x32_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [WIDTH-1:0]  write_data;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [WIDTH-1:0]  read_data1;
  logic [WIDTH-1:0]  read_data2;

  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2,
    input  read_data1, read_data2
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2,
    output read_data1, read_data2
  );
endinterface

// File: rtl/reg_file_32x32.sv
// 32 x 32-bit register file, r0 hardwired to zero.
//   clk   : single clock, all state updates on rising edge
//   reset : synchronous active-high, clears r1..r31
//   bus   : reg_file_32x32_if.slave (one write port, two combinational read
//           ports with same-cycle write-to-read bypass)
module reg_file_32x32 #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  reg_file_32x32_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam int NRD  = 2;

  // Storage only for r1..r(NREG-1); r0 exists only as a constant row in rows.
  logic [NREG-1:1][WIDTH-1:0]  regs_q, regs_d;
  logic [NREG-1:0][WIDTH-1:0]  rows;
  logic [NRD-1:0][ADDR_W-1:0]  rd_addr;
  logic [NRD-1:0][WIDTH-1:0]   rd_data;
  logic                        wr_en, byp_en;

  // A write to address 0 is simply not a write.
  assign wr_en  = bus.reg_write && (bus.write_reg != '0);
  // Bypass is suppressed during reset so reads show stored contents.
  assign byp_en = wr_en && !reset;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[bus.write_reg] = bus.write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign rows    = {regs_q, {WIDTH{1'b0}}};
  assign rd_addr = {bus.read_reg2, bus.read_reg1};

  // Address 0 can never hit the bypass (wr_en excludes it), so rows[0]
  // alone supplies the zero.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rd_data[g] = (byp_en && (bus.write_reg == rd_addr[g])) ?
                        bus.write_data : rows[rd_addr[g]];
  end

  assign bus.read_data1 = rd_data[0];
  assign bus.read_data2 = rd_data[1];
endmodule

// File: tb/tb_reg_file_32x32.sv
module tb_reg_file_32x32;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] model [32];

  reg_file_32x32_if #(.WIDTH(32), .ADDR_W(5)) bif ();

  reg_file_32x32 #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read: r0 is zero, a live non-reset write to the same address
  // wins, otherwise the architectural register value.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!reset && bif.reg_write && bif.write_reg != 5'd0 && bif.write_reg == a)
      return bif.write_data;
    return model[a];
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    reset          = rst;
    bif.reg_write  = we;
    bif.write_reg  = wr;
    bif.write_data = wd;
    bif.read_reg1  = r1;
    bif.read_reg2  = r2;
    #1;
  endtask

  // Advance one edge and update the architectural model from the inputs
  // that were present at that edge.
  task automatic tick;
    @(posedge clk);
    if (reset) for (int i = 0; i < 32; i++) model[i] = 32'h0;
    else if (bif.reg_write && bif.write_reg != 5'd0) model[bif.write_reg] = bif.write_data;
    @(negedge clk);
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 5'(a), 5'(31 - a));
      total++;
      if (bif.read_data1 !== 32'h0 || bif.read_data2 !== 32'h0) begin
        bad++;
        $display("FAIL reset_all addr=%0d got %h/%h want 0/0", a, bif.read_data1, bif.read_data2);
      end
    end
    drive(0, 1, 5, 32'hAAAAAAAA, 0, 0); tick();
    drive(0, 1, 31, 32'h55555555, 0, 0); tick();
    // During reset: bypass disabled, stored contents visible.
    drive(1, 1, 10, 32'h12121212, 5, 10);
    total++;
    if (bif.read_data1 !== 32'hAAAAAAAA || bif.read_data2 !== 32'h0) begin
      bad++;
      $display("FAIL reset_no_bypass got %h/%h want aaaaaaaa/00000000", bif.read_data1, bif.read_data2);
    end
    tick();
    drive(0, 0, 0, 0, 5, 31);
    total++;
    if (bif.read_data1 !== 32'h0 || bif.read_data2 !== 32'h0) begin
      bad++;
      $display("FAIL reset_clear got %h/%h want 0/0", bif.read_data1, bif.read_data2);
    end
    drive(0, 0, 0, 0, 10, 10);
    total++;
    if (bif.read_data1 !== 32'h0) begin
      bad++;
      $display("FAIL reset_beats_write got %h want 0", bif.read_data1);
    end
  endtask

  task automatic test_write_read;
    drive(0, 1, 1, 32'h00001240, 0, 0); tick();
    drive(0, 1, 2, 32'hAAAAAAAA, 0, 0); tick();
    drive(0, 1, 3, 32'h55555555, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 2);
    total++;
    if (bif.read_data1 !== 32'h00001240 || bif.read_data2 !== 32'hAAAAAAAA) begin
      bad++;
      $display("FAIL wr_rd_12 got %h/%h want 00001240/aaaaaaaa", bif.read_data1, bif.read_data2);
    end
    drive(0, 0, 0, 0, 3, 3);
    total++;
    if (bif.read_data1 !== 32'h55555555 || bif.read_data2 !== 32'h55555555) begin
      bad++;
      $display("FAIL wr_rd_33 got %h/%h want 55555555/55555555", bif.read_data1, bif.read_data2);
    end
  endtask

  task automatic test_r0;
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0);
    total++;
    if (bif.read_data1 !== 32'h0 || bif.read_data2 !== 32'h0) begin
      bad++;
      $display("FAIL r0_no_bypass got %h/%h want 0/0", bif.read_data1, bif.read_data2);
    end
    tick();
    drive(0, 0, 0, 0, 0, 1);
    total++;
    if (bif.read_data1 !== 32'h0 || bif.read_data2 !== 32'h00001240) begin
      bad++;
      $display("FAIL r0_after got %h/%h want 0/00001240", bif.read_data1, bif.read_data2);
    end
  endtask

  task automatic test_bypass;
    drive(0, 1, 7, 32'h1, 0, 0); tick();
    drive(0, 1, 7, 32'h12345678, 7, 7);
    total++;
    if (bif.read_data1 !== 32'h12345678 || bif.read_data2 !== 32'h12345678) begin
      bad++;
      $display("FAIL bypass_both got %h/%h want 12345678/12345678", bif.read_data1, bif.read_data2);
    end
    tick();
    drive(0, 0, 7, 32'h0, 7, 7);
    total++;
    if (bif.read_data1 !== 32'h12345678 || bif.read_data2 !== 32'h12345678) begin
      bad++;
      $display("FAIL bypass_stored got %h/%h want 12345678/12345678", bif.read_data1, bif.read_data2);
    end
    // One port hits the bypass, the other reads storage.
    drive(0, 1, 2, 32'hCAFEF00D, 2, 7);
    total++;
    if (bif.read_data1 !== 32'hCAFEF00D || bif.read_data2 !== 32'h12345678) begin
      bad++;
      $display("FAIL bypass_one got %h/%h want cafef00d/12345678", bif.read_data1, bif.read_data2);
    end
    tick();
  endtask

  task automatic test_write_disable;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 9, 32'hDEADBEEF, 9, 9);
      total++;
      if (bif.read_data1 !== 32'h0) begin
        bad++;
        $display("FAIL wdis_during cyc=%0d got %h want 0", k, bif.read_data1);
      end
      tick();
    end
    drive(0, 0, 0, 0, 9, 2);
    total++;
    if (bif.read_data1 !== 32'h0 || bif.read_data2 !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL wdis_after got %h/%h want 0/cafef00d", bif.read_data1, bif.read_data2);
    end
  endtask

  task automatic test_back_to_back;
    drive(0, 1, 12, 32'h11111111, 12, 0);
    total++;
    if (bif.read_data1 !== 32'h11111111) begin
      bad++;
      $display("FAIL b2b_byp1 got %h want 11111111", bif.read_data1);
    end
    tick();
    drive(0, 1, 12, 32'h22222222, 12, 12);
    total++;
    if (bif.read_data1 !== 32'h22222222) begin
      bad++;
      $display("FAIL b2b_byp2 got %h want 22222222", bif.read_data1);
    end
    tick();
    drive(0, 0, 0, 0, 12, 12);
    total++;
    if (bif.read_data2 !== 32'h22222222) begin
      bad++;
      $display("FAIL b2b_last got %h want 22222222", bif.read_data2);
    end
  endtask

  task automatic test_sweep;
    for (int i = 1; i < 32; i++) begin
      drive(0, 1, 5'(i), i * 32'h01010101, 0, 0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i));
      total++;
      if (bif.read_data1 !== i * 32'h01010101 || bif.read_data2 !== (31 - i) * 32'h01010101) begin
        bad++;
        $display("FAIL sweep i=%0d got %h/%h want %h/%h", i, bif.read_data1, bif.read_data2,
                 i * 32'h01010101, (31 - i) * 32'h01010101);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      e1 = exp_rd(bif.read_reg1);
      e2 = exp_rd(bif.read_reg2);
      total++;
      if (bif.read_data1 !== e1 || bif.read_data2 !== e2) begin
        bad++;
        $display("FAIL rand n=%0d rst=%0b we=%0b wr=%0d r=%0d/%0d got %h/%h want %h/%h",
                 n, reset, bif.reg_write, bif.write_reg, bif.read_reg1, bif.read_reg2,
                 bif.read_data1, bif.read_data2, e1, e2);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b1;
    bif.reg_write = 1'b0; bif.write_reg = '0; bif.write_data = '0;
    bif.read_reg1 = '0;   bif.read_reg2 = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_write_disable();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
